// File: rtl/arbitro_memoria_programa.sv
// Round-robin arbiter sharing the single program/data memory port between the
// host loader and the processor core, using a fixed three-cycle req/ack transaction.
module arbitro_memoria_programa #(
   parameter int LARGO_DIRECCION = 6,
   parameter int LARGO_DATO      = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       host_req,
   input  logic                       host_wr,
   input  logic [LARGO_DIRECCION-1:0] host_dir,
   input  logic [LARGO_DATO-1:0]      host_dato,
   output logic                       host_ack,
   output logic [LARGO_DATO-1:0]      host_dato_leido,
   input  logic                       cpu_req,
   input  logic                       cpu_wr,
   input  logic [LARGO_DIRECCION-1:0] cpu_dir,
   input  logic [LARGO_DATO-1:0]      cpu_dato,
   output logic                       cpu_ack,
   output logic [LARGO_DATO-1:0]      cpu_dato_leido,
   output logic                       mem_en,
   output logic                       mem_wr,
   output logic [LARGO_DIRECCION-1:0] mem_dir,
   output logic [LARGO_DATO-1:0]      mem_dato_escrito,
   input  logic [LARGO_DATO-1:0]      mem_dato_leido,
   output logic                       ocupado
);

   typedef enum logic [1:0] {
      INACTIVO = 2'd0,
      ACCESO   = 2'd1,
      LECTURA  = 2'd2
   } estado_t;

   estado_t estado, estado_sig;

   logic                       host_eleg, cpu_eleg;
   logic                       conceder, elige_cpu, fin;
   logic                       ultimo_cpu, atendido_cpu, atendido_wr;
   logic                       sel_wr;
   logic [LARGO_DIRECCION-1:0] sel_dir;
   logic [LARGO_DATO-1:0]      sel_dato;

   // A port whose ack is still high is masked, so a held req re-arbitrates one cycle later.
   assign host_eleg = host_req && !host_ack;
   assign cpu_eleg  = cpu_req  && !cpu_ack;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) estado <= INACTIVO;
      else        estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      conceder   = 1'b0;
      elige_cpu  = 1'b0;
      fin        = 1'b0;
      case (estado)
         INACTIVO: begin
            if (host_eleg || cpu_eleg) begin
               conceder   = 1'b1;
               elige_cpu  = cpu_eleg && (!host_eleg || !ultimo_cpu);
               estado_sig = ACCESO;
            end
         end
         ACCESO:  estado_sig = LECTURA;
         LECTURA: begin
            fin        = 1'b1;
            estado_sig = INACTIVO;
         end
         default: estado_sig = INACTIVO;
      endcase
   end

   assign sel_wr   = elige_cpu ? cpu_wr   : host_wr;
   assign sel_dir  = elige_cpu ? cpu_dir  : host_dir;
   assign sel_dato = elige_cpu ? cpu_dato : host_dato;
   assign ocupado  = (estado == ACCESO) || (estado == LECTURA);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_en           <= 1'b0;
         mem_wr           <= 1'b0;
         mem_dir          <= '0;
         mem_dato_escrito <= '0;
         host_ack         <= 1'b0;
         cpu_ack          <= 1'b0;
         host_dato_leido  <= '0;
         cpu_dato_leido   <= '0;
         ultimo_cpu       <= 1'b1;
         atendido_cpu     <= 1'b0;
         atendido_wr      <= 1'b0;
      end else begin
         mem_en   <= conceder;
         mem_wr   <= conceder && sel_wr;
         host_ack <= fin && !atendido_cpu;
         cpu_ack  <= fin && atendido_cpu;
         if (conceder) begin
            mem_dir          <= sel_dir;
            mem_dato_escrito <= sel_dato;
            atendido_cpu     <= elige_cpu;
            atendido_wr      <= sel_wr;
         end
         // Read data arrives one cycle after the strobe; writes leave dato_leido untouched.
         if (fin) begin
            ultimo_cpu <= atendido_cpu;
            if (!atendido_wr) begin
               if (atendido_cpu) cpu_dato_leido  <= mem_dato_leido;
               else              host_dato_leido <= mem_dato_leido;
            end
         end
      end
   end

endmodule

// File: tb/tb_arbitro_memoria_programa.sv
// Scoreboard bench for arbitro_memoria_programa: a behavioural one-cycle-latency RAM,
// directed transactions, and a monitor that checks every ack against a queue.
module tb_arbitro_memoria_programa;

   typedef struct {
      bit          es_cpu;
      logic [11:0] dato;
   } esperado_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        host_req = 1'b0, host_wr = 1'b0;
   logic [5:0]  host_dir = '0;
   logic [11:0] host_dato = '0;
   logic        host_ack;
   logic [11:0] host_dato_leido;
   logic        cpu_req = 1'b0, cpu_wr = 1'b0;
   logic [5:0]  cpu_dir = '0;
   logic [11:0] cpu_dato = '0;
   logic        cpu_ack;
   logic [11:0] cpu_dato_leido;
   logic        mem_en, mem_wr;
   logic [5:0]  mem_dir;
   logic [11:0] mem_dato_escrito;
   logic [11:0] mem_dato_leido = '0;
   logic        ocupado;

   logic [11:0] ram [64];
   esperado_t   cola [$];
   int          ciclos_ack [$];
   int          ciclo = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic        prev_host_ack = 1'b0, prev_cpu_ack = 1'b0;

   arbitro_memoria_programa #(.LARGO_DIRECCION(6), .LARGO_DATO(12)) dut (
      .clk(clk), .reset(reset),
      .host_req(host_req), .host_wr(host_wr), .host_dir(host_dir), .host_dato(host_dato),
      .host_ack(host_ack), .host_dato_leido(host_dato_leido),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_dir(cpu_dir), .cpu_dato(cpu_dato),
      .cpu_ack(cpu_ack), .cpu_dato_leido(cpu_dato_leido),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_dir(mem_dir),
      .mem_dato_escrito(mem_dato_escrito), .mem_dato_leido(mem_dato_leido),
      .ocupado(ocupado)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ciclo <= ciclo + 1;
      if (mem_en) begin
         if (mem_wr) ram[mem_dir] <= mem_dato_escrito;
         else        mem_dato_leido <= ram[mem_dir];
      end
   end

   task automatic chk(input string nombre, input logic [31:0] real_v, input logic [31:0] esp);
      n_tests++;
      if (real_v !== esp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nombre, real_v, esp);
      end
   endtask

   task automatic vencido(input string nombre);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout waiting for DUT", nombre);
   endtask

   // Monitor: every ack pops the next expected (port, data) pair.
   always @(negedge clk) begin
      if (host_ack || cpu_ack) begin
         ciclos_ack.push_back(ciclo);
         chk("dual_ack", {31'd0, host_ack && cpu_ack}, 32'd0);
         if (host_ack) chk("host_ack_width", {31'd0, prev_host_ack}, 32'd0);
         if (cpu_ack)  chk("cpu_ack_width", {31'd0, prev_cpu_ack}, 32'd0);
         if (cola.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: got host=%0b cpu=%0b required none", host_ack, cpu_ack);
         end else begin
            esperado_t e;
            e = cola.pop_front();
            chk("ack_port", {31'd0, cpu_ack}, {31'd0, e.es_cpu});
            chk("dato_leido", {20'd0, cpu_ack ? cpu_dato_leido : host_dato_leido}, {20'd0, e.dato});
         end
      end
      prev_host_ack = host_ack;
      prev_cpu_ack  = cpu_ack;
   end

   task automatic empujar(input bit es_cpu, input logic [11:0] dato);
      esperado_t e;
      e.es_cpu = es_cpu;
      e.dato   = dato;
      cola.push_back(e);
   endtask

   // Holds req for n acks on one port, then drops it.
   task automatic transaccion(input bit es_cpu, input int n, input logic wr,
                              input logic [5:0] dir, input logic [11:0] dato);
      if (es_cpu) begin cpu_wr = wr; cpu_dir = dir; cpu_dato = dato; cpu_req = 1'b1; end
      else begin host_wr = wr; host_dir = dir; host_dato = dato; host_req = 1'b1; end
      for (int k = 0; k < n; k++) begin
         int t;
         for (t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (es_cpu ? cpu_ack : host_ack) break;
         end
         if (t == 40) vencido(es_cpu ? "cpu_ack_wait" : "host_ack_wait");
      end
      if (es_cpu) cpu_req = 1'b0;
      else        host_req = 1'b0;
   endtask

   task automatic esperar_mem_en(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk); #1;
         if (mem_en) begin ok = 1'b1; break; end
      end
      if (!ok) vencido("mem_en_wait");
   endtask

   initial begin
      bit ok;
      for (int i = 0; i < 64; i++) ram[i] = 12'h000;

      // Reset held with both requesters active.
      host_req = 1'b1; cpu_req = 1'b1; host_dir = 6'd3; cpu_dir = 6'd4;
      repeat (3) @(negedge clk);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mem_dir", {26'd0, mem_dir}, 32'd0);
      chk("rst_mem_dato", {20'd0, mem_dato_escrito}, 32'd0);
      chk("rst_acks", {30'd0, host_ack, cpu_ack}, 32'd0);
      chk("rst_dato_leido", {8'd0, host_dato_leido, cpu_dato_leido}, 32'd0);
      chk("rst_ocupado", {31'd0, ocupado}, 32'd0);

      @(posedge clk); #1;
      reset = 1'b1;
      empujar(1'b0, 12'h000);
      empujar(1'b1, 12'h000);
      fork
         transaccion(1'b0, 1, 1'b0, 6'd3, 12'h000);
         transaccion(1'b1, 1, 1'b0, 6'd4, 12'h000);
         begin
            @(posedge clk); #1;
            chk("first_grant_en", {31'd0, mem_en}, 32'd1);
            chk("first_grant_host", {26'd0, mem_dir}, 32'd3);
            chk("first_grant_ocupado", {31'd0, ocupado}, 32'd1);
         end
      join

      // Host load then readback of address 5.
      empujar(1'b0, 12'h000);
      fork
         transaccion(1'b0, 1, 1'b1, 6'd5, 12'h1A5);
         begin
            esperar_mem_en(ok);
            if (ok) begin
               chk("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
               chk("wr_mem_dir", {26'd0, mem_dir}, 32'd5);
               chk("wr_mem_dato", {20'd0, mem_dato_escrito}, 32'h1A5);
               @(posedge clk); #1;
               chk("wr_en_one_cycle", {31'd0, mem_en}, 32'd0);
               @(posedge clk); #1;
               chk("wr_ack_latency", {31'd0, host_ack}, 32'd1);
            end
         end
      join
      empujar(1'b0, 12'h1A5);
      transaccion(1'b0, 1, 1'b0, 6'd5, 12'h000);

      // Contention: preload, then both ports hold req across two transactions each.
      empujar(1'b0, 12'h1A5);
      transaccion(1'b0, 1, 1'b1, 6'd0, 12'h0AA);
      empujar(1'b1, 12'h000);
      transaccion(1'b1, 1, 1'b1, 6'd63, 12'h555);
      ciclos_ack.delete();
      empujar(1'b0, 12'h0AA);
      empujar(1'b1, 12'h555);
      empujar(1'b0, 12'h0AA);
      empujar(1'b1, 12'h555);
      fork
         transaccion(1'b0, 2, 1'b0, 6'd0, 12'h000);
         transaccion(1'b1, 2, 1'b0, 6'd63, 12'h000);
      join
      @(negedge clk);
      chk("contention_acks", ciclos_ack.size(), 32'd4);
      if (ciclos_ack.size() == 4)
         for (int i = 1; i < 4; i++)
            chk("contention_gap", ciclos_ack[i] - ciclos_ack[i-1], 32'd3);

      // Field stability: cpu_dir changes after grant.
      empujar(1'b0, 12'h0AA);
      transaccion(1'b0, 1, 1'b1, 6'd10, 12'h2B2);
      empujar(1'b1, 12'h2B2);
      cpu_wr = 1'b0; cpu_dir = 6'd10; cpu_req = 1'b1;
      esperar_mem_en(ok);
      chk("stab_grant_dir", {26'd0, mem_dir}, 32'd10);
      cpu_dir = 6'd20;
      @(posedge clk); #1;
      chk("stab_dir_held", {26'd0, mem_dir}, 32'd10);
      begin
         int t;
         for (t = 0; t < 10; t++) begin
            if (cpu_ack) break;
            @(posedge clk); #1;
         end
         if (t == 10) vencido("stab_ack_wait");
      end
      cpu_req = 1'b0;

      // Reset abort during ACCESO of a host write.
      empujar(1'b0, 12'h0AA);
      transaccion(1'b0, 1, 1'b1, 6'd7, 12'h321);
      host_wr = 1'b1; host_dir = 6'd7; host_dato = 12'hFFF; host_req = 1'b1;
      esperar_mem_en(ok);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_mem_en_async", {31'd0, mem_en}, 32'd0);
      host_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_no_ack", {30'd0, host_ack, cpu_ack}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      empujar(1'b0, 12'h321);
      transaccion(1'b0, 1, 1'b0, 6'd7, 12'h000);

      // Write/read data isolation on the cpu port.
      empujar(1'b1, 12'h000);
      transaccion(1'b1, 1, 1'b1, 6'd30, 12'h456);
      empujar(1'b1, 12'h456);
      transaccion(1'b1, 1, 1'b0, 6'd30, 12'h000);
      empujar(1'b1, 12'h456);
      transaccion(1'b1, 1, 1'b1, 6'd31, 12'h123);
      empujar(1'b1, 12'h123);
      transaccion(1'b1, 1, 1'b0, 6'd31, 12'h000);

      repeat (4) @(negedge clk);
      chk("queue_drained", cola.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
